// File: rtl/fifo_pkg.sv
// Shared defaults and status bundle for the single-clock flagged FIFO.
package fifo_pkg;

    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 4;

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic walmost_full;
        logic ralmost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifomem.sv
// Dual-port storage array: synchronous write, asynchronous read.
module fifomem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    output logic [DSIZE-1:0] rdata,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] waddr,
    input  logic [ASIZE-1:0] raddr,
    input  logic             wclken,
    input  logic             wfull,
    input  logic             wclk
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [0:DEPTH-1];

    assign rdata = r_mem[raddr];

    always_ff @(posedge wclk) begin
        if (wclken && !wfull)
            r_mem[waddr] <= wdata;
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, threshold flags, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads (head word visible with zero latency).
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int ASIZE = FIFO_ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic [ASIZE:0]   afull_thresh,
    input  logic [ASIZE:0]   aempty_thresh,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    logic [ASIZE:0]   r_wptr, r_rptr;
    logic             r_overflow, r_underflow;
    logic [ASIZE:0]   w_count;
    logic             w_full, w_empty;
    logic             w_wacc, w_racc;
    logic             w_set_ovf, w_set_udf;
    logic [DSIZE-1:0] w_memrd;
    fifo_status_t     w_status;

    // Everything below is decoded from registered pointers only.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                     (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);

    assign w_wacc    = winc && !w_full  && !flush;
    assign w_racc    = rinc && !w_empty && !flush;
    assign w_set_ovf = winc && w_full  && !flush;
    assign w_set_udf = rinc && w_empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wacc) r_wptr <= r_wptr + 1'b1;
            if (w_racc) r_rptr <= r_rptr + 1'b1;
        end
    end

    // A set event in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_set_ovf)    r_overflow  <= 1'b1;
            else if (clr_err) r_overflow  <= 1'b0;
            if (w_set_udf)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    fifomem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .rdata  (w_memrd),
        .wdata  (wdata),
        .waddr  (r_wptr[ASIZE-1:0]),
        .raddr  (r_rptr[ASIZE-1:0]),
        .wclken (winc && !flush),
        .wfull  (w_full),
        .wclk   (clk)
    );

`ifdef FIFO_FWFT_EN
    assign rdata = w_memrd;
`else
    logic [DSIZE-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= '0;
        else if (w_racc)
            r_rdata <= w_memrd;
    end

    assign rdata = r_rdata;
`endif

    assign w_status.wfull         = w_full;
    assign w_status.rempty        = w_empty;
    assign w_status.walmost_full  = (w_count >= afull_thresh);
    assign w_status.ralmost_empty = (w_count <= aempty_thresh);
    assign w_status.overflow      = r_overflow;
    assign w_status.underflow     = r_underflow;

    assign wfull         = w_status.wfull;
    assign rempty        = w_status.rempty;
    assign walmost_full  = w_status.walmost_full;
    assign ralmost_empty = w_status.ralmost_empty;
    assign overflow      = w_status.overflow;
    assign underflow     = w_status.underflow;
    assign count         = w_count;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed/random bench for sync_fifo_flags with a queue scoreboard and flag model.
module tb_sync_fifo_flags;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             clr_err = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [ASIZE:0]   afull_thresh = 5'd14;
    logic [ASIZE:0]   aempty_thresh = 5'd2;
    logic [DSIZE-1:0] rdata;
    logic             wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [ASIZE:0]   count;

    sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .clr_err       (clr_err),
        .wdata         (wdata),
        .winc          (winc),
        .rinc          (rinc),
        .afull_thresh  (afull_thresh),
        .aempty_thresh (aempty_thresh),
        .rdata         (rdata),
        .wfull         (wfull),
        .rempty        (rempty),
        .walmost_full  (walmost_full),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    int         max_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".count"},  32'(count), 32'(n));
        chk({tag, ".wfull"},  32'(wfull), 32'(n == DEPTH));
        chk({tag, ".rempty"}, 32'(rempty), 32'(n == 0));
        chk({tag, ".afull"},  32'(walmost_full), 32'(n >= int'(afull_thresh)));
        chk({tag, ".aempty"}, 32'(ralmost_empty), 32'(n <= int'(aempty_thresh)));
        chk({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"},    32'(underflow), 32'(m_udf));
`ifndef FIFO_FWFT_EN
        chk({tag, ".rdata"},  32'(rdata), 32'(m_rdata));
`endif
        if (32'(count) > 32'(max_cnt)) max_cnt = int'(count);
    endtask

    // One clock cycle: drive at posedge+1, model acceptance, check at next posedge+1.
    task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d,
                        input logic fl = 1'b0, input logic ce = 1'b0);
        logic wacc, racc, set_o, set_u;
        logic [7:0] head;
        wacc  = w && !fl && (m_q.size() < DEPTH);
        racc  = r && !fl && (m_q.size() > 0);
        set_o = w && !fl && (m_q.size() == DEPTH);
        set_u = r && !fl && (m_q.size() == 0);
        winc = w; rinc = r; wdata = d; flush = fl; clr_err = ce;
`ifdef FIFO_FWFT_EN
        if (racc) begin
            #1;
            chk({tag, ".fwft"}, 32'(rdata), 32'(m_q[0]));
        end
`endif
        @(posedge clk); #1;
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0;
        if (racc) begin
            head = m_q.pop_front();
            m_rdata = head;
        end
        if (wacc) m_q.push_back(d);
        if (fl) m_q.delete();
        if (set_o) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
        if (set_u) m_udf = 1'b1; else if (ce) m_udf = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int written;
        logic w, r;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");

        // fill 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i));

        // threshold above depth: almost-full never asserts
        afull_thresh = 5'd17;
        #1 chk("afull_gt_depth", 32'(walmost_full), 32'(0));
        afull_thresh = 5'd14;
        #1;

        // drain in order
        for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);

        // refill, then simultaneous read/write while full
        for (int i = 1; i <= DEPTH; i++) step("refill", 1'b1, 1'b0, 8'(8'h20 + i));
        step("full_rw", 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < DEPTH - 1; i++) step("drain2", 1'b0, 1'b1, 8'h00);

        // empty: simultaneous read/write, then clear sticky errors
        step("empty_rw", 1'b1, 1'b1, 8'h5A);
        step("clr_err", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("pop_5a", 1'b0, 1'b1, 8'h00);

        // random stream of 40 words across pointer wraps
        written = 0;
        for (int k = 0; k < 600 && (written < 40 || m_q.size() > 0); k++) begin
            w = (written < 40) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            if (w && m_q.size() < DEPTH) begin
                step("stream", w, r, 8'(8'h40 + written));
                written++;
            end else begin
                step("stream", w, r, 8'(8'h40 + written));
            end
        end
        chk("stream_words", 32'(written), 32'(40));
        chk("stream_drained", 32'(m_q.size()), 32'(0));
        chk("max_count_le_depth", 32'(max_cnt <= DEPTH), 32'(1));
        step("clr_err2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // flush with a concurrent write
        for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 1'b0, 8'(8'h80 + i));
        step("flush", 1'b1, 1'b0, 8'hEE, 1'b1);
        step("post_flush_wr", 1'b1, 1'b0, 8'h99);
        step("post_flush_rd", 1'b0, 1'b1, 8'h00);

        // async reset mid-stream
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'hC0 + i));
        step("set_udf", 1'b0, 1'b1, 8'h00);
        step("rd_rst", 1'b0, 1'b1, 8'h00);
        step("rd_rst2", 1'b0, 1'b1, 8'h00);
        step("udf_on", 1'b0, 1'b1, 8'h00);
        winc = 1'b1; wdata = 8'h77;
        #3 rst = 1'b1;
        #1;
        m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rdata = 8'h00;
        check_all("async_rst");
        winc = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check_all("rst_release");
        step("after_rst_wr", 1'b1, 1'b0, 8'h3C);
        step("after_rst_rd", 1'b0, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
